// File: rtl/seq_sort_engine_if.sv
// Sample-in / sorted-out stream bundle for seq_sort_engine.
// master = upstream/downstream side, slave = the engine.
interface seq_sort_if #(
  parameter int DATA_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/seq_sort_engine.sv
// Serial-load, odd-even transposition sorter streaming the sorted frame
// out ascending or descending; median of the last frame held on out_med.
module seq_sort_engine #(
  parameter int DATA_W = 6,
  parameter int NUM    = 5,
  parameter int CNT_W  = $clog2(NUM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  seq_sort_if.slave         sif,
  output logic [DATA_W-1:0] out_med,
  output logic              busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM - 1);

  state_e state_q, state_d;

  logic [DATA_W-1:0] arr_q [NUM];
  logic [DATA_W-1:0] arr_d [NUM];
  logic [DATA_W-1:0] swp   [NUM];
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  oidx_q, oidx_d;
  logic              mode_q, mode_d;

  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_med_q, out_med_d;
  logic              busy_q, busy_d;

  logic             accept;
  logic             hs;
  logic [CNT_W-1:0] end_oidx;

  assign accept   = (state_q == LOAD) && sif.in_valid && in_ready_q;
  assign hs       = out_valid_q && sif.out_ready;
  assign end_oidx = mode_q ? '0 : LAST_IDX;

  // One transposition stage; pairs are disjoint so in-order updates are safe.
  always_comb begin
    swp = arr_q;
    for (int unsigned i = 0; i < unsigned'(NUM - 1); i++) begin
      if ((i[0] == pass_q[0]) && (arr_q[i] > arr_q[i+1])) begin
        swp[i]   = arr_q[i+1];
        swp[i+1] = arr_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: if (accept && (idx_q == LAST_IDX)) state_d = SORT;
      SORT: if (pass_q == LAST_IDX)            state_d = OUT;
      OUT:  if (hs && (oidx_q == end_oidx))    state_d = LOAD;
      default:                                 state_d = LOAD;
    endcase
  end

  always_comb begin
    arr_d  = arr_q;
    idx_d  = idx_q;
    pass_d = pass_q;
    oidx_d = oidx_q;
    mode_d = mode_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          arr_d[idx_q] = sif.in_data;
          if (idx_q == '0) mode_d = sif.mode;
          idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          pass_d = '0;
        end
      end
      SORT: begin
        arr_d = swp;
        if (pass_q == LAST_IDX) begin
          pass_d = '0;
          oidx_d = mode_q ? LAST_IDX : '0;
        end else begin
          pass_d = pass_q + 1'b1;
        end
      end
      OUT: begin
        // oidx parks on the final element rather than wrapping.
        if (hs && (oidx_q != end_oidx)) begin
          oidx_d = mode_q ? oidx_q - 1'b1 : oidx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != LOAD);
    out_data_d  = out_valid_d ? arr_d[oidx_d] : '0;
    out_last_d  = out_valid_d && (oidx_d == end_oidx);
    out_med_d   = out_med_q;
    if ((state_q == SORT) && (state_d == OUT)) out_med_d = arr_d[NUM/2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < unsigned'(NUM); i++) arr_q[i] <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      oidx_q      <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_med_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      arr_q       <= arr_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      oidx_q      <= oidx_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_med_q   <= out_med_d;
      busy_q      <= busy_d;
    end
  end

  assign sif.in_ready  = in_ready_q;
  assign sif.out_valid = out_valid_q;
  assign sif.out_data  = out_data_q;
  assign sif.out_last  = out_last_q;
  assign out_med       = out_med_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_seq_sort_engine.sv
// Directed bench for seq_sort_engine (NUM=5, DATA_W=6) with hand-computed results.
module tb_seq_sort_engine;

  typedef logic [5:0] frame_t [5];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] out_med;
  logic       busy;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         acc_cyc = 0;

  seq_sort_if #(.DATA_W(6)) sif ();

  seq_sort_engine #(.DATA_W(6), .NUM(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .sif     (sif),
    .out_med (out_med),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the final accept.
  task automatic send(input frame_t d, input logic m, input bit gap, input bit hold,
                      input logic [5:0] hold_data);
    for (int k = 0; k < 5; k++) begin
      int g;
      sif.in_valid = 1'b1;
      sif.in_data  = d[k];
      sif.mode     = (k == 0) ? m : ~m;
      g = 0;
      while (!sif.in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) check("in_ready_timeout", 1, 0);
      acc_cyc = cyc;
      @(negedge clk);
      if (gap && k < 4) begin
        sif.in_valid = 1'b0;
        sif.in_data  = 6'h3f;
        @(negedge clk);
      end
    end
    sif.in_valid = hold;
    sif.in_data  = hold_data;
  endtask

  // Called on a negedge; returns on the negedge after the out_last handshake.
  task automatic recv(input string tag, input frame_t exp, input logic [5:0] med,
                      input int stall_at, input int stall_len, input bit chk_lat);
    bit saw_ready = 1'b0;
    sif.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int g = 0;
      while (!sif.out_valid && g < 50) begin
        if (sif.in_ready) saw_ready = 1'b1;
        @(negedge clk);
        g++;
      end
      if (g >= 50) check({tag, "_timeout"}, 1, 0);
      if (k == 0) begin
        if (chk_lat) check({tag, "_latency"}, 32'(cyc - acc_cyc), 6);
        check({tag, "_busy"}, {31'b0, busy}, 1);
        check({tag, "_med"}, {26'b0, out_med}, {26'b0, med});
      end
      if (sif.in_ready) saw_ready = 1'b1;
      check($sformatf("%s_data%0d", tag, k), {26'b0, sif.out_data}, {26'b0, exp[k]});
      check($sformatf("%s_last%0d", tag, k), {31'b0, sif.out_last}, (k == 4) ? 1 : 0);
      if (k == stall_at) begin
        sif.out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check($sformatf("%s_hold%0d", tag, s), {25'b0, sif.out_valid, sif.out_data},
                {25'b1, exp[k]});
        end
        sif.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check({tag, "_in_ready_low"}, {31'b0, saw_ready}, 0);
    check({tag, "_done"}, {29'b0, sif.out_valid, busy, sif.in_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.mode      = 1'b0;
    sif.out_ready = 1'b0;
    #2;
    check("rst_in_ready", {31'b0, sif.in_ready}, 0);
    check("rst_out_valid", {31'b0, sif.out_valid}, 0);
    check("rst_out_data", {26'b0, sif.out_data}, 0);
    check("rst_out_last", {31'b0, sif.out_last}, 0);
    check("rst_out_med", {26'b0, out_med}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, sif.in_ready}, 1);

    send('{12, 5, 63, 0, 5}, 1'b0, 1'b0, 1'b0, 6'd0);
    recv("asc", '{0, 5, 5, 12, 63}, 6'd5, -1, 0, 1'b1);

    send('{12, 5, 63, 0, 5}, 1'b1, 1'b0, 1'b0, 6'd0);
    recv("desc", '{63, 12, 5, 5, 0}, 6'd5, -1, 0, 1'b1);

    send('{40, 30, 20, 10, 0}, 1'b0, 1'b0, 1'b0, 6'd0);
    recv("stall", '{0, 10, 20, 30, 40}, 6'd20, 2, 2, 1'b0);

    send('{63, 63, 63, 63, 63}, 1'b0, 1'b0, 1'b1, 6'd1);
    recv("b2b1", '{63, 63, 63, 63, 63}, 6'd63, -1, 0, 1'b0);
    send('{1, 2, 3, 4, 5}, 1'b0, 1'b0, 1'b0, 6'd0);
    recv("b2b2", '{1, 2, 3, 4, 5}, 6'd3, -1, 0, 1'b1);

    send('{7, 6, 5, 4, 3}, 1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, sif.out_valid}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_in_ready", {31'b0, sif.in_ready}, 0);
    check("midrst_out_med", {26'b0, out_med}, 0);
    @(negedge clk);
    rst = 1'b0;
    sif.out_ready = 1'b1;
    begin
      bit saw_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (sif.out_valid || busy) saw_valid = 1'b1;
      end
      check("midrst_no_output", {31'b0, saw_valid}, 0);
    end
    check("midrst_in_ready_after", {31'b0, sif.in_ready}, 1);
    send('{2, 1, 2, 1, 2}, 1'b0, 1'b0, 1'b0, 6'd0);
    recv("after_rst", '{1, 1, 2, 2, 2}, 6'd2, -1, 0, 1'b1);

    send('{9, 8, 7, 6, 5}, 1'b0, 1'b1, 1'b0, 6'd0);
    recv("gap", '{5, 6, 7, 8, 9}, 6'd7, -1, 0, 1'b1);

    repeat (3) @(negedge clk);
    check("med_retained", {26'b0, out_med}, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_sort_engine.md
Name: seq_sort_engine

Overview:
- Clocked, parametrised successor to the team's combinational 5-input 6-bit sorter.
- Accepts a frame of NUM unsigned samples serially over a valid/ready handshake.
- Sorts the frame in place with an odd-even transposition network, one compare-swap stage per cycle.
- Streams the sorted frame out in ascending or descending order, with backpressure. The median is also held on a side output.

Parameters:
- DATA_W, 6, width of each unsigned sample.
- NUM, 5, samples per frame; legal range 2..32.
- CNT_W, $clog2(NUM+1), width of the internal index and pass counters (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  unsigned sample.
- in_ready  output  1  engine accepts a sample this cycle.
- mode  input  1  0 = ascending output, 1 = descending; sampled with the first sample of a frame.
- out_valid  output  1  out_data is valid.
- out_data  output  DATA_W  current sorted element.
- out_last  output  1  marks the final element of the frame.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_med  output  DATA_W  median of the last sorted frame: element index NUM/2 in ascending order, integer division.
- busy  output  1  high in SORT and OUT.

Behaviour:
- Reset values: in_ready=0 while rst is asserted, 1 in the first cycle after release. out_valid=0, out_data=0, out_last=0, out_med=0, busy=0. Internal array, counters and latched mode are all 0. FSM enters LOAD.
- FSM states are LOAD, SORT and OUT. There is no separate idle state; LOAD with idx=0 is idle.
- LOAD:
  - in_ready=1.
  - An accept is in_valid && in_ready. It writes in_data to arr[idx] and increments idx.
  - The accept at idx=0 also latches mode.
  - The accept at idx=NUM-1 goes to SORT with pass=0.
  - in_valid low holds state; there is no timeout.
- SORT:
  - in_ready=0 and busy=1.
  - Even passes compare-swap pairs (0,1),(2,3),... and odd passes compare-swap pairs (1,2),(3,4),...
  - A swap occurs only when arr[i] > arr[i+1], an unsigned strict compare, so equal values never swap.
  - Exactly NUM passes run, one per cycle. After pass NUM-1 the FSM goes to OUT, out_med is registered from arr[NUM/2], and the output index is set to 0 (ascending) or NUM-1 (descending).
- OUT:
  - out_valid=1.
  - out_data=arr[oidx] and out_last=1 when the element is the final one of the frame.
  - A handshake is out_valid && out_ready. It advances oidx by +1 (ascending) or -1 (descending).
  - With out_ready=0, out_data and out_last hold stable.
  - The handshake on the last element returns the FSM to LOAD with idx=0. in_ready=1 on the next cycle.
- Latency: the last input accept is at edge t. SORT occupies cycles t+1..t+NUM. out_valid is first high in cycle t+NUM+1. With out_ready held high, a frame drains in NUM cycles.
- Outputs are registered. out_data is driven from registered state only and has no combinational path from in_data.
- in_valid during SORT/OUT is ignored (in_ready=0). Those samples are not stored, and upstream must hold them.
- out_med stays constant until the next frame completes SORT. It is not cleared on return to LOAD.
- Mode changes during a frame have no effect on that frame.
- Reset asserted mid-frame (LOAD, SORT or OUT) discards the frame. All outputs take their reset values immediately, asynchronously. No partial output is emitted after reset release.
- Width rules: no arithmetic on data; only compares. oidx must not wrap; it stops at the boundary.

Test Plan:
- NUM=5, mode=0, inputs 12,5,63,0,5, out_ready=1 -> out 0,5,5,12,63; out_last on 63; out_med=5; first out_valid 6 cycles after the last accept.
- Same inputs, mode=1 -> out 63,12,5,5,0; out_last on 0; out_med=5.
- Mode=0, inputs 40,30,20,10,0, out_ready low for 2 cycles on the 3rd element -> out_data holds 20 for 3 cycles; full stream is 0,10,20,30,40 with no loss or duplication.
- Back-to-back frames 63,63,63,63,63 then 1,2,3,4,5 with in_valid held high -> in_ready=0 throughout SORT/OUT; frame 2 accepted from the cycle after frame 1's out_last handshake; outputs 63x5 then 1..5; out_med=63 then 3.
- rst pulsed during SORT of frame 7,6,5,4,3 -> out_valid stays 0, busy=0, in_ready=1 after release. A new frame 2,1,2,1,2 then yields 1,1,2,2,2 and out_med=2.
- in_valid toggled 1,0,1,0... during LOAD with inputs 9,8,7,6,5 -> only the asserted cycles are accepted; sorted output 5,6,7,8,9.
